// File: rtl/mbus_arbiter_if.sv
// mbus_arbiter_if: bus bundle between two Wishbone masters, the arbiter and the memory bus switch.
// slave modport: arbiter view (takes m0/m1 requests and slave responses, drives routed bus and returns).
// master modport: environment view (drives master requests and slave responses).
interface mbus_arbiter_if;
  logic        m0_stb_i, m0_we_i, m0_ack_o, m0_err_o;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m1_stb_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  modport slave (
    input  m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    input  m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    input  s_dat_i, s_ack_i,
    output m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
  modport master (
    output m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
    output m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
    output s_dat_i, s_ack_i,
    input  m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
  );
endinterface

// File: rtl/mbus_arbiter.sv
// mbus_arbiter: two-master round-robin Wishbone arbiter with one transfer per grant and a watchdog abort.
// Ports: clk_i clock, rst_i async active-high reset, bus (slave modport) carrying both masters and the slave side.
module mbus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  mbus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t          state, state_n;
  logic            last, last_n;
  logic [TO_W-1:0] cnt;
  logic            g0, g1, stb, to_hit;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      // every grant is entered from IDLE, so a grant that persists keeps counting and anything else clears
      cnt   <= (state != IDLE && state_n == state) ? cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    g0      = state == GNT0;
    g1      = state == GNT1;
    stb     = g1 ? bus.m1_stb_i : g0 ? bus.m0_stb_i : 1'b0;
    // ack has priority over the watchdog in the same cycle
    to_hit  = stb & ~bus.s_ack_i & (cnt == TO_W'(TIMEOUT - 1));
    state_n = state;
    last_n  = last;
    if (state == IDLE) begin
      if (bus.m0_stb_i & (~bus.m1_stb_i | last)) state_n = GNT0;
      else if (bus.m1_stb_i) state_n = GNT1;
    end else if (~stb | bus.s_ack_i | to_hit) begin
      state_n = IDLE;
      last_n  = g1;
    end
    bus.s_cyc_o  = stb;
    bus.s_stb_o  = stb;
    bus.s_we_o   = g1 ? bus.m1_we_i  : g0 ? bus.m0_we_i  : 1'b0;
    bus.s_adr_o  = g1 ? bus.m1_adr_i : g0 ? bus.m0_adr_i : '0;
    bus.s_dat_o  = g1 ? bus.m1_dat_i : g0 ? bus.m0_dat_i : '0;
    bus.s_sel_o  = g1 ? bus.m1_sel_i : g0 ? bus.m0_sel_i : '0;
    bus.m0_dat_o = bus.s_dat_i;
    bus.m1_dat_o = bus.s_dat_i;
    bus.m0_ack_o = bus.s_ack_i & g0;
    bus.m1_ack_o = bus.s_ack_i & g1;
    bus.m0_err_o = to_hit & g0;
    bus.m1_err_o = to_hit & g1;
  end
endmodule

// File: tb/tb_mbus_arbiter.sv
// tb_mbus_arbiter: scoreboard bench for mbus_arbiter with directed transfers and hand-computed event cycles.
module tb_mbus_arbiter;
  localparam int TIMEOUT = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  mbus_arbiter_if bus();
  mbus_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  typedef struct {logic we; logic [31:0] adr; logic [3:0] sel; logic [31:0] dat;} req_t;
  typedef struct {logic [3:0] ev; logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; int cyc;} exp_t;
  localparam logic [3:0] ACK0 = 4'b0001, ACK1 = 4'b0010, ERR0 = 4'b0100, ERR1 = 4'b1000;
  req_t tab0[$], tab1[$];
  exp_t sb[$];
  int   tests = 0, fails = 0, cyc = 0, age = 0, ack_wait = 0;
  logic ack_en = 0;
  // slave model: acks when the strobe has been up for ack_wait cycles; read data derived from address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    age <= bus.s_stb_o ? age + 1 : 0;
  end
  assign bus.s_ack_i = ack_en & bus.s_stb_o & (age == ack_wait);
  assign bus.s_dat_i = {16'h5A5A, bus.s_adr_o[15:0]};
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h (cycle %0d)", n, got, exp, cyc);
    end
  endtask
  function automatic req_t rq(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    rq = '{we, adr, sel, dat};
  endfunction
  function automatic void expect_ev(input logic [3:0] ev, input req_t r, input int c);
    sb.push_back('{ev, r.adr, r.we, r.sel, r.dat, c});
  endfunction
  task automatic set_m(input bit m, input logic stb, input req_t r);
    if (m) begin
      bus.m1_stb_i = stb; bus.m1_we_i = r.we; bus.m1_adr_i = r.adr; bus.m1_sel_i = r.sel; bus.m1_dat_i = r.dat;
    end else begin
      bus.m0_stb_i = stb; bus.m0_we_i = r.we; bus.m0_adr_i = r.adr; bus.m0_sel_i = r.sel; bus.m0_dat_i = r.dat;
    end
  endtask
  // master model: holds stb across its table, changing payload after each ack/err, then drops
  task automatic run_master(input bit m);
    req_t r;
    int   n;
    bit   done;
    while ((m ? tab1.size() : tab0.size()) != 0) begin
      if (m) r = tab1.pop_front(); else r = tab0.pop_front();
      set_m(m, 1'b1, r);
      n = 0;
      done = 0;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
        done = m ? (bus.m1_ack_o | bus.m1_err_o) : (bus.m0_ack_o | bus.m0_err_o);
      end
      if (!done) chk(m ? "m1_wait_bound" : "m0_wait_bound", n, 0);
      @(posedge clk); #1;
    end
    if (m) bus.m1_stb_i = 0; else bus.m0_stb_i = 0;
  endtask
  always @(negedge clk) begin
    logic [3:0] ev;
    exp_t       e;
    ev = {bus.m1_err_o, bus.m0_err_o, bus.m1_ack_o, bus.m0_ack_o};
    if (!rst && ev != 0) begin
      if (sb.size() == 0) chk("unexpected_event", ev, 0);
      else begin
        e = sb.pop_front();
        chk("event", ev, e.ev);
        chk("event_cycle", cyc, e.cyc);
        chk("cyc_stb", {bus.s_cyc_o, bus.s_stb_o}, 2'b11);
        chk("adr", bus.s_adr_o, e.adr);
        chk("we", bus.s_we_o, e.we);
        chk("sel", bus.s_sel_o, e.sel);
        if (e.we) chk("wdat", bus.s_dat_o, e.dat);
        else chk("rdat", (e.ev & (ACK1 | ERR1)) != 0 ? bus.m1_dat_o : bus.m0_dat_o, {16'h5A5A, e.adr[15:0]});
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int c;
    set_m(0, 0, rq(0, 0, 0, 0));
    set_m(1, 0, rq(0, 0, 0, 0));
    #12;
    chk("rst_ctrl", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o}, 0);
    chk("rst_adr", bus.s_adr_o, 0);
    chk("rst_dat", bus.s_dat_o, 0);
    chk("rst_m0_dat", bus.m0_dat_o, 32'h5A5A_0000);
    chk("rst_m1_dat", bus.m1_dat_o, 32'h5A5A_0000);
    @(posedge clk); #1;
    rst = 0;
    // contention from reset: m0 first, strict alternation, ack 2 cycles after strobe
    c = cyc; ack_en = 1; ack_wait = 2;
    tab0.push_back(rq(0, 32'h1000, 4'hF, 0));
    tab0.push_back(rq(1, 32'h1004, 4'b1100, 32'h1111_2222));
    tab1.push_back(rq(1, 32'h2000, 4'b0011, 32'hDEAD_BEEF));
    tab1.push_back(rq(0, 32'h2008, 4'hF, 0));
    expect_ev(ACK0, tab0[0], c + 3);
    expect_ev(ACK1, tab1[0], c + 7);
    expect_ev(ACK0, tab0[1], c + 11);
    expect_ev(ACK1, tab1[1], c + 15);
    fork run_master(0); run_master(1); join
    // single zero-wait read
    c = cyc; ack_wait = 0;
    tab0.push_back(rq(0, 32'h100, 4'hF, 0));
    expect_ev(ACK0, tab0[0], c + 1);
    fork
      run_master(0);
      begin @(negedge clk); chk("single_stb_idle", bus.s_stb_o, 0); end
    join
    // timeout on m1 with m0 pending
    c = cyc; ack_en = 0;
    tab1.push_back(rq(0, 32'h3000, 4'hF, 0));
    tab0.push_back(rq(0, 32'h3100, 4'hF, 0));
    expect_ev(ERR1, tab1[0], c + TIMEOUT);
    expect_ev(ACK0, tab0[0], c + TIMEOUT + 2);
    fork
      run_master(1);
      begin repeat (2) @(posedge clk); #1; run_master(0); end
      begin
        repeat (TIMEOUT + 1) @(posedge clk); #1;
        ack_en = 1; ack_wait = 0;
        @(negedge clk);
        chk("cyc_after_err", bus.s_cyc_o, 0);
      end
    join
    // abort: m0 drops stb after 2 wait cycles, m1 follows
    c = cyc; ack_en = 0;
    set_m(0, 1, rq(0, 32'h5000, 4'hF, 0));
    repeat (3) @(posedge clk); #1;
    bus.m0_stb_i = 0;
    @(negedge clk);
    chk("abort_ack", bus.m0_ack_o, 0);
    chk("abort_stb", bus.s_stb_o, 0);
    @(posedge clk); #1;
    ack_en = 1; ack_wait = 0;
    tab1.push_back(rq(0, 32'h5100, 4'hF, 0));
    expect_ev(ACK1, tab1[0], c + 5);
    fork
      run_master(1);
      begin @(negedge clk); chk("abort_idle", bus.s_cyc_o, 0); end
    join
    // ack arrives in the same cycle as the timeout
    c = cyc; ack_wait = TIMEOUT - 1;
    tab0.push_back(rq(1, 32'h4000, 4'b0101, 32'hCAFE_F00D));
    expect_ev(ACK0, tab0[0], c + TIMEOUT);
    run_master(0);
    // reset during GNT1, then contention must go to m0
    ack_en = 0;
    set_m(1, 1, rq(1, 32'h6000, 4'b1010, 32'h1234_5678));
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_stb", bus.s_stb_o, 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("mid_rst_ctrl", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.m0_ack_o, bus.m0_err_o, bus.m1_ack_o, bus.m1_err_o}, 0);
    chk("mid_rst_adr", bus.s_adr_o, 0);
    chk("mid_rst_dat", bus.s_dat_o, 0);
    @(posedge clk); #1;
    rst = 0;
    c = cyc; ack_en = 1; ack_wait = 0;
    tab0.push_back(rq(0, 32'h7000, 4'hF, 0));
    tab1.push_back(rq(0, 32'h7100, 4'hF, 0));
    expect_ev(ACK0, tab0[0], c + 1);
    expect_ev(ACK1, tab1[0], c + 3);
    fork run_master(0); run_master(1); join
    @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mbus_arbiter.md
# mbus_arbiter

Two-master Wishbone arbiter for the on-chip memory bus. It sits between the BIU memory port (master 0) and a second bus master such as a DMA or debug loader (master 1), and the memory bus switch. It grants the bus round-robin, one transfer per grant, and routes the acknowledge back to the winning master. A watchdog aborts any transfer that is never acknowledged.

## Interface
- TIMEOUT, 255: cycles a granted transfer may wait for `s_ack_i` before it is aborted; legal range 1..(2^TO_W − 1).
- TO_W, 8: width of the timeout counter.

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- m0_stb_i  in  1  master 0 request; held until ack or err.
- m0_we_i  in  1  master 0 write enable.
- m0_adr_i  in  32  master 0 address.
- m0_dat_i  in  32  master 0 write data.
- m0_sel_i  in  4  master 0 byte selects.
- m0_dat_o  out  32  read data to master 0.
- m0_ack_o  out  1  transfer complete to master 0.
- m0_err_o  out  1  timeout abort to master 0.
- m1_*: the same eight signals for master 1.
- s_cyc_o  out  1  bus cycle to the slave side.
- s_stb_o  out  1  strobe to the slave side.
- s_we_o  out  1  write enable to the slave side.
- s_adr_o  out  32  address to the slave side.
- s_dat_o  out  32  write data to the slave side.
- s_sel_o  out  4  byte selects to the slave side.
- s_dat_i  in  32  read data from the slave side.
- s_ack_i  in  1  acknowledge from the slave side.

## Operation
- FSM states: IDLE, GNT0, GNT1. Registered state `last` records the last granted master.
- IDLE:
  - If only mX_stb_i is high, go to GNTX.
  - If both are high, grant the master that is not `last`.
  - If neither is high, stay in IDLE.
- GNTX, slave-side signals:
  - `s_cyc_o = s_stb_o = mX_stb_i`.
  - `s_we_o`, `s_adr_o`, `s_dat_o` and `s_sel_o` are combinationally muxed from master X.
- IDLE, slave-side signals: `s_cyc_o` and `s_stb_o` are 0; the address, data, select and write-enable outputs are 0.
- Read data: `m0_dat_o` and `m1_dat_o` are always driven from `s_dat_i`.
- Acknowledge: `mX_ack_o = s_ack_i & (state == GNTX)`. It is combinational and never reaches the non-granted master.
- Leaving GNTX:
  - On `s_ack_i`: go to IDLE and set `last := X`.
  - If mX_stb_i drops before ack (master abort): go to IDLE, set `last := X`, and generate no ack.
- Timeout counter:
  - Clears on entry to GNT0 or GNT1.
  - Increments each GNT cycle in which `s_ack_i` is 0.
  - When count == TIMEOUT − 1 and `s_ack_i` is 0: assert `mX_err_o` for that cycle only, then go to IDLE with `last := X`. `s_cyc_o` is 0 from the next cycle.
- Simultaneous `s_ack_i` and timeout in the same cycle: the ack wins and err stays 0.
- One transfer per grant. A master holding `stb` after its ack is re-arbitrated in IDLE, where a pending other master wins.

## Timing
- Reset values:
  - state = IDLE, `last` = 1 (so master 0 wins the first contention), counter = 0.
  - All outputs 0, except `mX_dat_o`, which follows `s_dat_i`.
- Reset asserted mid-transfer: `s_cyc_o` and `s_stb_o` drop asynchronously, and no ack or err is issued.
- Latency:
  - Request sampled high in IDLE at edge N puts the FSM in GNTX after N.
  - `s_stb_o` is high in cycle N+1.
  - With a zero-wait slave, ack arrives in cycle N+1.
- Throughput:
  - Each transfer is followed by one IDLE cycle, so back-to-back zero-wait transfers complete every 2 cycles.
  - Two contending masters alternate strictly.
- `mX_err_o` pulses exactly one cycle, TIMEOUT cycles after `s_stb_o` rose.

## Test plan
- Single read: m0_stb_i=1 with adr 0x0000_0100 and a zero-wait slave → `s_stb_o` rises 1 cycle later with `s_adr_o`=0x100; `m0_ack_o` is 1 for one cycle; `m1_ack_o` stays 0.
- Contention: m0 and m1 both request continuously from reset, with slave ack 2 cycles after strobe → grants go m0, m1, m0, m1. Each `s_adr_o` matches the granted master. Per-transfer `sel` and `we` pass through unchanged (m1 write with sel=4'b0011 and dat 0xDEAD_BEEF).
- Timeout: with TIMEOUT=8, m1 requests and the slave never acks → `m1_err_o` is high exactly in the 8th cycle of `s_stb_o`; `s_cyc_o` is 0 the cycle after; a pending m0 is then granted.
- Ack at limit: `s_ack_i` arrives in the same cycle as the timeout → `m0_ack_o`=1 and `m0_err_o`=0.
- Abort: m0 drops `stb` after 2 wait cycles → no ack; FSM returns to IDLE; a subsequent m1 request is granted 1 cycle later.
- Reset mid-transfer: assert `rst_i` while in GNT1 → all outputs 0 immediately. After release, simultaneous requests grant m0 first.
